// File: rtl/wb_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : trace_pkg
// Description : Shared types for the writeback commit tracer. Holds the capture
//               mode and FSM state encodings, the default-width trace entry
//               and a helper that folds the raw 2-bit mode input onto the three
//               supported modes.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

   localparam int c_TRACE_PC_W   = 32;
   localparam int c_TRACE_RA_W   = 5;
   localparam int c_TRACE_DATA_W = 32;

   typedef enum logic [1:0] {
      MODE_CIRC = 2'd0,
      MODE_FILL = 2'd1,
      MODE_TRIG = 2'd2
   } trace_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_POST   = 2'd2,
      ST_FROZEN = 2'd3
   } trace_state_e;

   // One captured commit at the package default widths.
   typedef struct packed {
      logic [c_TRACE_PC_W-1:0]   pc;
      logic [c_TRACE_RA_W-1:0]   rd;
      logic [c_TRACE_DATA_W-1:0] data;
   } trace_entry_t;

   // Encoding 3 is unused by the board logic and behaves as circular capture.
   function automatic trace_mode_e decode_mode(input logic [1:0] i_mode);
      trace_mode_e v_mode;
      case (i_mode)
         2'd1:    v_mode = MODE_FILL;
         2'd2:    v_mode = MODE_TRIG;
         default: v_mode = MODE_CIRC;
      endcase
      return v_mode;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : wb_trace_buffer_if
// Description : Commit capture, control and readout signals of the tracer.
//               master : driven by the CPU WB stage / board control logic
//               slave  : the tracer itself
// Signals     : commit_valid/pc/rd/data  - one WB commit per cycle
//               mode, arm, stop           - capture control
//               trig_pc, post_count       - trigger setup for TRIG mode
//               rd_req, rd_idx            - readout request (0 = oldest)
//               rd_valid/hit/pc/rd/data   - registered readout response
//               count, state, overflow, triggered - status
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_trace_buffer_if #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
);
   logic              commit_valid;
   logic [PC_W-1:0]   commit_pc;
   logic [RA_W-1:0]   commit_rd;
   logic [DATA_W-1:0] commit_data;
   logic [1:0]        mode;
   logic              arm;
   logic              stop;
   logic [PC_W-1:0]   trig_pc;
   logic [CNT_W-1:0]  post_count;
   logic              rd_req;
   logic [CNT_W-1:0]  rd_idx;
   logic              rd_valid;
   logic              rd_hit;
   logic [PC_W-1:0]   rd_pc;
   logic [RA_W-1:0]   rd_rd;
   logic [DATA_W-1:0] rd_data;
   logic [CNT_W-1:0]  count;
   logic [1:0]        state;
   logic              overflow;
   logic              triggered;

   modport master (
      output commit_valid, commit_pc, commit_rd, commit_data,
      output mode, arm, stop, trig_pc, post_count, rd_req, rd_idx,
      input  rd_valid, rd_hit, rd_pc, rd_rd, rd_data,
      input  count, state, overflow, triggered
   );

   modport slave (
      input  commit_valid, commit_pc, commit_rd, commit_data,
      input  mode, arm, stop, trig_pc, post_count, rd_req, rd_idx,
      output rd_valid, rd_hit, rd_pc, rd_rd, rd_data,
      output count, state, overflow, triggered
   );
endinterface
`default_nettype wire

// File: rtl/wb_trace_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : trace_ram
// Description : Simple dual-port RAM, DEPTH x WIDTH. One synchronous write
//               port, one synchronous read port with a registered output.
//               A read and write to the same address in one cycle returns the
//               previous contents (read-before-write).
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable; o_rdata updates only when set
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 69
) (
   input  wire logic                     clk,
   input  wire logic                     i_we,
   input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
   input  wire logic [WIDTH-1:0]         i_wdata,
   input  wire logic                     i_re,
   input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic      [WIDTH-1:0]         o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // No reset on the array or the read register so this maps onto block RAM;
   // the parent masks the read data with its own reset-cleared hit flag.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wb_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_buffer
// Description : Writeback commit tracer. Captures (PC, rd, data) commits into a
//               circular buffer with CIRC / FILL / TRIG capture modes, PC
//               trigger with post-trigger count, stop/freeze control, sticky
//               overflow/triggered flags and a 1-cycle registered readout.
// Ports       : clk     - clock, all flops rising edge
//               reset_n - asynchronous active-low reset
//               bus     - wb_trace_buffer_if slave modport (commit, control,
//                         readout and status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   wb_trace_buffer_if.slave bus
);

   localparam int               c_AW       = $clog2(DEPTH);
   localparam int               c_EW       = PC_W + RA_W + DATA_W;
   localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_POST_MAX = CNT_W'(DEPTH - 1);

   trace_state_e      r_state, w_state_nx;
   logic [c_AW-1:0]   r_wr_ptr, w_wr_ptr_nx;
   logic [CNT_W-1:0]  r_count, w_count_nx;
   logic [CNT_W-1:0]  r_remain, w_remain_nx;
   logic              r_overflow, w_overflow_nx;
   logic              r_triggered, w_triggered_nx;
   logic              w_we;

   logic              r_rd_valid;
   logic              r_rd_hit;

   trace_mode_e       w_mode;
   logic              w_pc_match;
   logic [CNT_W-1:0]  w_post_sat;
   logic [c_AW-1:0]   w_rd_addr;
   logic              w_rd_hit;
   logic [c_EW-1:0]   w_ram_q;

   assign w_mode     = decode_mode(bus.mode);
   assign w_pc_match = (bus.commit_pc == bus.trig_pc);
   assign w_post_sat = (bus.post_count > c_POST_MAX) ? c_POST_MAX : bus.post_count;

   // ------------------------------------------------------------------------
   // FSM state register and capture bookkeeping
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_remain    <= '0;
         r_overflow  <= 1'b0;
         r_triggered <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_wr_ptr    <= w_wr_ptr_nx;
         r_count     <= w_count_nx;
         r_remain    <= w_remain_nx;
         r_overflow  <= w_overflow_nx;
         r_triggered <= w_triggered_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. arm dominates everything (the coincident commit is
   // dropped); stop is applied after the commit so that commit is kept.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nx     = r_state;
      w_wr_ptr_nx    = r_wr_ptr;
      w_count_nx     = r_count;
      w_remain_nx    = r_remain;
      w_overflow_nx  = r_overflow;
      w_triggered_nx = r_triggered;
      w_we           = 1'b0;

      if (bus.arm) begin
         w_state_nx     = ST_ARMED;
         w_wr_ptr_nx    = '0;
         w_count_nx     = '0;
         w_remain_nx    = '0;
         w_overflow_nx  = 1'b0;
         w_triggered_nx = 1'b0;
      end else if (r_state == ST_ARMED || r_state == ST_POST) begin
         if (bus.commit_valid) begin
            w_we        = 1'b1;
            // DEPTH is a power of two, so the pointer wraps by overflowing.
            w_wr_ptr_nx = r_wr_ptr + c_AW'(1);
            if (r_count == c_FULL) begin
               w_overflow_nx = 1'b1;
            end else begin
               w_count_nx = r_count + CNT_W'(1);
            end

            if (r_state == ST_POST) begin
               // Trigger matches are ignored while draining the post window.
               w_remain_nx = r_remain - CNT_W'(1);
               if (r_remain == CNT_W'(1)) begin
                  w_state_nx = ST_FROZEN;
               end
            end else begin
               case (w_mode)
                  MODE_FILL: begin
                     if (r_count >= c_FULL - CNT_W'(1)) begin
                        w_state_nx = ST_FROZEN;
                     end
                  end
                  MODE_TRIG: begin
                     if (w_pc_match) begin
                        w_triggered_nx = 1'b1;
                        if (w_post_sat == '0) begin
                           w_state_nx = ST_FROZEN;
                        end else begin
                           w_remain_nx = w_post_sat;
                           w_state_nx  = ST_POST;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end

         if (bus.stop) begin
            w_state_nx = ST_FROZEN;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Readout address mapping. (wr_ptr - count + rd_idx) mod DEPTH only
   // depends on the low log2(DEPTH) bits of each operand, so the sum is
   // formed directly at address width.
   // ------------------------------------------------------------------------
   assign w_rd_addr = r_wr_ptr - r_count[c_AW-1:0] + bus.rd_idx[c_AW-1:0];
   assign w_rd_hit  = (bus.rd_idx < r_count);

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (c_EW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata ({bus.commit_pc, bus.commit_rd, bus.commit_data}),
      .i_re    (bus.rd_req),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= bus.rd_req;
         if (bus.rd_req) begin
            r_rd_hit <= w_rd_hit;
         end
      end
   end

   // Fields read zero on a miss and straight out of reset (r_rd_hit clears
   // asynchronously while the RAM output register does not).
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_hit    = r_rd_hit;
   assign bus.rd_pc     = r_rd_hit ? w_ram_q[c_EW-1 -: PC_W]          : '0;
   assign bus.rd_rd     = r_rd_hit ? w_ram_q[DATA_W+RA_W-1 -: RA_W]   : '0;
   assign bus.rd_data   = r_rd_hit ? w_ram_q[DATA_W-1:0]              : '0;
   assign bus.count     = r_count;
   assign bus.state     = r_state;
   assign bus.overflow  = r_overflow;
   assign bus.triggered = r_triggered;

endmodule
`default_nettype wire
